// File: rtl/fetch_unit_l2_pkg.sv
// Shared types for the L2 fetch unit: memory opcodes, default reset address
// and the buffered response entry.
package fetch_unit_l2_pkg;

    typedef enum logic [1:0] {
        MEM_MSG_READ  = 2'd0,
        MEM_MSG_WRITE = 2'd1
    } mem_op_e;

    localparam logic [31:0] DEFAULT_RST_ADDR = 32'h0000_0200;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_entry_t;

    function automatic logic [31:0] next_fetch_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_resp_fifo.sv
// Response buffer for the fetch unit: power-of-two depth, synchronous clear,
// simultaneous push/pop allowed even when full.
module fetch_resp_fifo
    import fetch_unit_l2_pkg::*;
#(
    parameter int p_depth = 8
)(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clr,
    input  logic                          i_push,
    input  fetch_entry_t                  i_push_entry,
    input  logic                          i_pop,
    output fetch_entry_t                  o_head,
    output logic                          o_empty,
    output logic [$clog2(p_depth):0]      o_count
);

    localparam int AW = $clog2(p_depth);
    localparam int CW = AW + 1;

    fetch_entry_t      r_mem [p_depth];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_full    = (r_count == CW'(p_depth));
    assign w_do_pop  = i_pop && (r_count != CW'(0));
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == CW'(0));
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else if (i_clr) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit_l2.sv
// Instruction fetch unit: credit-limited sequential requests to memory,
// in-order response buffering, squash/redirect with stale-response dropping.
module fetch_unit_l2
    import fetch_unit_l2_pkg::*;
#(
    parameter logic [31:0] p_rst_addr      = DEFAULT_RST_ADDR,
    parameter int          p_resp_depth    = 8,
    parameter int          p_max_in_flight = 4,
    parameter int          p_seq_num_bits  = 8
)(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    output logic                      o_mem_req_val,
    input  logic                      i_mem_req_rdy,
    output logic [1:0]                o_mem_req_op,
    output logic [31:0]               o_mem_req_addr,
    output logic [7:0]                o_mem_req_opaque,
    output logic [3:0]                o_mem_req_strb,
    output logic [31:0]               o_mem_req_data,
    input  logic                      i_mem_resp_val,
    output logic                      o_mem_resp_rdy,
    input  logic [31:0]               i_mem_resp_data,
    output logic                      o_d_val,
    input  logic                      i_d_rdy,
    output logic [31:0]               o_d_inst,
    output logic [31:0]               o_d_pc,
    output logic [p_seq_num_bits-1:0] o_d_seq_num,
    input  logic                      i_squash_val,
    input  logic [31:0]               i_squash_pc
);

    localparam int CW = $clog2(p_resp_depth) + 1;

    logic [31:0]               r_curr_addr;
    logic [31:0]               r_resp_addr;
    logic [CW-1:0]             r_in_flight;
    logic [CW-1:0]             r_drop_cnt;
    logic [p_seq_num_bits-1:0] r_seq_num;
    logic [CW-1:0]             w_fifo_count;
    logic [CW:0]               w_occupancy;
    logic                      w_req_val;
    logic                      w_req_xfer;
    logic                      w_resp_xfer;
    logic                      w_drop;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_empty;
    fetch_entry_t              w_head;
    fetch_entry_t              w_push_entry;

    // Requests and buffered responses together may never exceed the buffer,
    // so an always-ready response port can never overflow it.
    assign w_occupancy = {1'b0, r_in_flight} + {1'b0, w_fifo_count};
    assign w_req_val   = i_rst_n && !i_squash_val
                      && (w_occupancy < (CW+1)'(p_resp_depth))
                      && (r_in_flight < CW'(p_max_in_flight));
    assign w_req_xfer  = w_req_val && i_mem_req_rdy;
    assign w_resp_xfer = i_mem_resp_val;
    assign w_drop      = w_resp_xfer && (i_squash_val || (r_drop_cnt != CW'(0)));
    assign w_push      = w_resp_xfer && !w_drop;
    assign w_pop       = o_d_val && i_d_rdy;

    assign w_push_entry = '{addr: r_resp_addr, data: i_mem_resp_data};

    assign o_mem_req_val    = w_req_val;
    assign o_mem_req_op     = MEM_MSG_READ;
    assign o_mem_req_addr   = r_curr_addr;
    assign o_mem_req_opaque = 8'h00;
    assign o_mem_req_strb   = 4'h0;
    assign o_mem_req_data   = 32'h0000_0000;
    assign o_mem_resp_rdy   = 1'b1;

    assign o_d_val     = !w_empty && !i_squash_val;
    assign o_d_inst    = w_head.data;
    assign o_d_pc      = w_head.addr;
    assign o_d_seq_num = r_seq_num;

    fetch_resp_fifo #(
        .p_depth (p_resp_depth)
    ) u_resp_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (i_squash_val),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_empty      (w_empty),
        .o_count      (w_fifo_count)
    );

    // Responses carry no address; the next kept response always belongs to
    // the oldest live request, so its pc is tracked as a running address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_curr_addr <= p_rst_addr;
            r_resp_addr <= p_rst_addr;
        end else if (i_squash_val) begin
            r_curr_addr <= i_squash_pc;
            r_resp_addr <= i_squash_pc;
        end else begin
            if (w_req_xfer) begin
                r_curr_addr <= next_fetch_addr(r_curr_addr);
            end
            if (w_push) begin
                r_resp_addr <= next_fetch_addr(r_resp_addr);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_flight <= CW'(0);
        end else if (w_req_xfer && !w_resp_xfer) begin
            r_in_flight <= r_in_flight + CW'(1);
        end else if (!w_req_xfer && w_resp_xfer && (r_in_flight != CW'(0))) begin
            r_in_flight <= r_in_flight - CW'(1);
        end
    end

    // Everything still outstanding at a squash is stale and must be discarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_cnt <= CW'(0);
        end else if (i_squash_val) begin
            r_drop_cnt <= (w_resp_xfer && (r_in_flight != CW'(0)))
                        ? r_in_flight - CW'(1) : r_in_flight;
        end else if (w_resp_xfer && (r_drop_cnt != CW'(0))) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seq_num <= p_seq_num_bits'(0);
        end else if (w_pop) begin
            r_seq_num <= r_seq_num + p_seq_num_bits'(1);
        end
    end

endmodule

// File: tb/tb_fetch_unit_l2.sv
// Self-checking bench for fetch_unit_l2: directed scenarios plus randomized
// traffic checked against a queue-based model of the fetch/squash rules.
module tb_fetch_unit_l2;
    import fetch_unit_l2_pkg::*;

    localparam int          DEPTH    = 8;
    localparam int          MAXF     = 4;
    localparam int          SEQW     = 8;
    localparam logic [31:0] RST_ADDR = 32'h0000_0200;

    typedef struct { logic [31:0] addr; int rdy; } mreq_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

    logic            clk;
    logic            rst_n;
    logic            o_mem_req_val;
    logic            mem_req_rdy;
    logic [1:0]      o_mem_req_op;
    logic [31:0]     o_mem_req_addr;
    logic [7:0]      o_mem_req_opaque;
    logic [3:0]      o_mem_req_strb;
    logic [31:0]     o_mem_req_data;
    logic            mem_resp_val;
    logic            o_mem_resp_rdy;
    logic [31:0]     mem_resp_data;
    logic            o_d_val;
    logic            d_rdy;
    logic [31:0]     o_d_inst;
    logic [31:0]     o_d_pc;
    logic [SEQW-1:0] o_d_seq_num;
    logic            squash_val;
    logic [31:0]     squash_pc;

    int              n_cmp = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              lat = 1;
    bit              jitter = 1'b0;
    mreq_t           mem_q[$];
    ent_t            exp_q[$];
    int              n_stale = 0;
    logic [31:0]     pc_next = RST_ADDR;
    logic [SEQW-1:0] exp_seq = '0;
    int              n_req = 0;
    int              os_dut = 0;
    int              max_os = 0;
    logic [31:0]     d_pc_log[$];
    logic [SEQW-1:0] d_seq_log[$];

    fetch_unit_l2 #(
        .p_rst_addr      (RST_ADDR),
        .p_resp_depth    (DEPTH),
        .p_max_in_flight (MAXF),
        .p_seq_num_bits  (SEQW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_mem_req_val    (o_mem_req_val),
        .i_mem_req_rdy    (mem_req_rdy),
        .o_mem_req_op     (o_mem_req_op),
        .o_mem_req_addr   (o_mem_req_addr),
        .o_mem_req_opaque (o_mem_req_opaque),
        .o_mem_req_strb   (o_mem_req_strb),
        .o_mem_req_data   (o_mem_req_data),
        .i_mem_resp_val   (mem_resp_val),
        .o_mem_resp_rdy   (o_mem_resp_rdy),
        .i_mem_resp_data  (mem_resp_data),
        .o_d_val          (o_d_val),
        .i_d_rdy          (d_rdy),
        .o_d_inst         (o_d_inst),
        .o_d_pc           (o_d_pc),
        .o_d_seq_num      (o_d_seq_num),
        .i_squash_val     (squash_val),
        .i_squash_pc      (squash_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // In-order memory: head response becomes valid lat cycles after acceptance.
    task automatic drive_mem();
        mem_resp_val  = 1'b0;
        mem_resp_data = 32'h0;
        if (rst_n && mem_q.size() != 0 && mem_q[0].rdy <= cyc
            && (!jitter || $urandom_range(0, 3) != 0)) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = memdata(mem_q[0].addr);
        end
        mem_req_rdy = (!jitter || $urandom_range(0, 3) != 0);
    endtask

    task automatic step();
        bit sq, rx, ereq, ed;
        mreq_t m;
        @(negedge clk);
        sq = squash_val;
        rx = mem_resp_val;
        if (!rst_n) begin
            chk("rst_req_val", 64'(o_mem_req_val), 64'(0));
            chk("rst_d_val", 64'(o_d_val), 64'(0));
            chk("rst_resp_rdy", 64'(o_mem_resp_rdy), 64'(1));
            mem_q.delete(); exp_q.delete();
            n_stale = 0; os_dut = 0; pc_next = RST_ADDR; exp_seq = '0;
        end else begin
            ereq = !sq && (mem_q.size() + exp_q.size() < DEPTH) && (mem_q.size() < MAXF);
            ed   = (exp_q.size() != 0) && !sq;
            chk("req_val", 64'(o_mem_req_val), 64'(ereq));
            if (ereq) begin
                chk("req_addr", 64'(o_mem_req_addr), 64'(pc_next));
                chk("req_fields", 64'({o_mem_req_op, o_mem_req_opaque, o_mem_req_strb}), 64'(0));
            end
            chk("resp_rdy", 64'(o_mem_resp_rdy), 64'(1));
            chk("d_val", 64'(o_d_val), 64'(ed));
            chk("d_seq", 64'(o_d_seq_num), 64'(exp_seq));
            if (ed) begin
                chk("d_pc", 64'(o_d_pc), 64'(exp_q[0].addr));
                chk("d_inst", 64'(o_d_inst), 64'(exp_q[0].data));
            end
            if (o_mem_req_val && mem_req_rdy) begin
                n_req++;
                os_dut++;
            end
            if (rx) os_dut--;
            if (os_dut > max_os) max_os = os_dut;
            if (o_d_val && d_rdy) begin
                d_pc_log.push_back(o_d_pc);
                d_seq_log.push_back(o_d_seq_num);
            end
            if (ed && d_rdy) begin
                void'(exp_q.pop_front());
                exp_seq = exp_seq + 8'd1;
            end
            if (rx && mem_q.size() != 0) begin
                m = mem_q.pop_front();
                if (n_stale > 0) n_stale--;
                else if (!sq) exp_q.push_back('{addr: m.addr, data: memdata(m.addr)});
            end
            if (sq) begin
                exp_q.delete();
                n_stale = mem_q.size();
                pc_next = squash_pc;
            end
            if (ereq && mem_req_rdy) begin
                mem_q.push_back('{addr: pc_next, rdy: cyc + lat});
                pc_next = pc_next + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        squash_val = 1'b0;
        mem_q.delete(); exp_q.delete();
        n_stale = 0; os_dut = 0; pc_next = RST_ADDR; exp_seq = '0;
        drive_mem();
        #1;
        chk("async_rst_req_val", 64'(o_mem_req_val), 64'(0));
        chk("async_rst_d_val", 64'(o_d_val), 64'(0));
        chk("async_rst_resp_rdy", 64'(o_mem_resp_rdy), 64'(1));
        chk("async_rst_seq", 64'(o_d_seq_num), 64'(0));
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n0, seq_b, infl;
        bit found;
        rst_n = 1'b1; squash_val = 1'b0; squash_pc = 32'h0; d_rdy = 1'b0;
        mem_resp_val = 1'b0; mem_resp_data = 32'h0; mem_req_rdy = 1'b1;
        #2;

        // Basic sequential fetch after reset
        lat = 1; jitter = 1'b0; d_rdy = 1'b1;
        do_reset();
        d_pc_log.delete(); d_seq_log.delete();
        repeat (8) step();
        chk("basic_count", 64'(d_pc_log.size() >= 3), 64'(1));
        for (int i = 0; i < 3; i++) begin
            chk("basic_pc", 64'((i < d_pc_log.size()) ? d_pc_log[i] : 32'hDEAD_BEEF),
                64'(RST_ADDR + 32'(4 * i)));
            chk("basic_seq", 64'((i < d_seq_log.size()) ? d_seq_log[i] : 8'hFF), 64'(i));
        end

        // Back-pressure from decode: credit stops at the buffer depth
        d_rdy = 1'b0;
        do_reset();
        n0 = n_req;
        repeat (30) step();
        chk("fill_reqs", 64'(n_req - n0), 64'(DEPTH));
        chk("fill_stall", 64'(o_mem_req_val), 64'(0));
        d_rdy = 1'b1;
        step();
        d_rdy = 1'b0;
        n0 = n_req;
        repeat (20) step();
        chk("refill_reqs", 64'(n_req - n0), 64'(1));

        // Long memory latency: outstanding cap and in-order delivery
        lat = 10; d_rdy = 1'b1;
        do_reset();
        max_os = 0;
        d_pc_log.delete(); d_seq_log.delete();
        repeat (120) step();
        chk("max_outstanding", 64'(max_os), 64'(MAXF));
        chk("lat10_count", 64'(d_pc_log.size() >= 20), 64'(1));
        for (int i = 0; i < d_pc_log.size(); i++) begin
            chk("lat10_pc", 64'(d_pc_log[i]), 64'(RST_ADDR + 32'(4 * i)));
        end

        // Squash with 3 in flight and 2 buffered
        lat = 4; d_rdy = 1'b1;
        do_reset();
        repeat (12) step();
        d_rdy = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (mem_q.size() == 3 && exp_q.size() == 2) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("sq_setup", 64'(found), 64'(1));
        seq_b = int'(exp_seq);
        squash_val = 1'b1; squash_pc = 32'h0000_1000;
        step();
        squash_val = 1'b0; d_rdy = 1'b1;
        d_pc_log.delete(); d_seq_log.delete();
        for (int k = 0; k < 60 && d_pc_log.size() < 3; k++) step();
        chk("sq_count", 64'(d_pc_log.size() >= 3), 64'(1));
        chk("sq_pc0", 64'((d_pc_log.size() > 0) ? d_pc_log[0] : 32'hDEAD_BEEF), 64'(32'h1000));
        chk("sq_pc1", 64'((d_pc_log.size() > 1) ? d_pc_log[1] : 32'hDEAD_BEEF), 64'(32'h1004));
        chk("sq_seq0", 64'((d_seq_log.size() > 0) ? d_seq_log[0] : 8'hFF), 64'(seq_b));

        // Squash colliding with a response and a ready decode stage
        lat = 2; d_rdy = 1'b0;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (mem_resp_val && exp_q.size() > 0 && mem_q.size() >= 2) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("col_setup", 64'(found), 64'(1));
        infl = mem_q.size();
        d_rdy = 1'b1; squash_val = 1'b1; squash_pc = 32'h0000_3000;
        step();
        squash_val = 1'b0;
        chk("col_drop_cnt", 64'(dut.r_drop_cnt), 64'(infl - 1));
        d_pc_log.delete(); d_seq_log.delete();
        repeat (20) step();
        chk("col_pc0", 64'((d_pc_log.size() > 0) ? d_pc_log[0] : 32'hDEAD_BEEF), 64'(32'h3000));

        // Randomized traffic with squashes, including address wrap
        jitter = 1'b1;
        for (int seg = 0; seg < 4; seg++) begin
            lat = $urandom_range(1, 6);
            for (int k = 0; k < 400; k++) begin
                d_rdy = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 29) == 0) begin
                    squash_val = 1'b1;
                    squash_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                             : ($urandom & 32'hFFFF_FFFC);
                end else begin
                    squash_val = 1'b0;
                end
                step();
            end
        end
        squash_val = 1'b0;

        // Reset mid-stream, then restart from the reset address
        do_reset();
        jitter = 1'b0; lat = 1; d_rdy = 1'b1;
        d_pc_log.delete(); d_seq_log.delete();
        repeat (8) step();
        chk("restart_pc0", 64'((d_pc_log.size() > 0) ? d_pc_log[0] : 32'hDEAD_BEEF), 64'(RST_ADDR));
        chk("restart_seq0", 64'((d_seq_log.size() > 0) ? d_seq_log[0] : 8'hFF), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
